// File: rtl/fpu_issue_ctrl.sv
// Single-outstanding issue controller in front of FPU_Main: launches A/B/S, waits, captures O.
// Latency: result captured LAT_op edges after acceptance; out_valid the cycle after that edge.
// Backpressure: out_ready low holds the result in DONE and keeps in_ready low; nothing is dropped.
module fpu_issue_ctrl #(
    parameter int LAT_ADD  = 4,
    parameter int LAT_SQRT = 8,
    parameter int LAT_MUL  = 4,
    parameter int LAT_DIV  = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic [1:0]  in_op,
    input  logic [3:0]  in_tag,
    output logic [31:0] fpu_a,
    output logic [31:0] fpu_b,
    output logic [1:0]  fpu_s,
    input  logic [31:0] fpu_o,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [3:0]  out_tag,
    output logic [2:0]  out_flags,
    output logic        busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0] state;
    logic [3:0] cnt;
    logic [3:0] tag_q;
    logic [3:0] lat_sel;
    logic [2:0] flags_nxt;

    // Pick the datapath latency for the operation being offered.
    always_comb begin
        lat_sel = 4'(LAT_ADD);
        case (in_op)
            2'b00:   lat_sel = 4'(LAT_ADD);
            2'b01:   lat_sel = 4'(LAT_SQRT);
            2'b10:   lat_sel = 4'(LAT_MUL);
            default: lat_sel = 4'(LAT_DIV);
        endcase
    end

    // Classify the value about to be captured: {nan, inf, zero}; denormals count as zero.
    always_comb begin
        flags_nxt = 3'b000;
        if (fpu_o[30:23] == 8'hFF) begin
            if (fpu_o[22:0] != 23'd0) flags_nxt = 3'b100;
            else                      flags_nxt = 3'b010;
        end else if (fpu_o[30:23] == 8'h00) begin
            flags_nxt = 3'b001;
        end
    end

    // Request/result FSM; operand lines only move when a request is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            tag_q      <= 4'd0;
            fpu_a      <= 32'd0;
            fpu_b      <= 32'd0;
            fpu_s      <= 2'b00;
            out_result <= 32'd0;
            out_tag    <= 4'd0;
            out_flags  <= 3'b000;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        fpu_a <= in_a;
                        fpu_b <= in_b;
                        fpu_s <= in_op;
                        tag_q <= in_tag;
                        cnt   <= lat_sel;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    // cnt==0 cannot occur with legal latencies; treat it as "done now" rather than wrap.
                    if (cnt <= 4'd1) begin
                        cnt        <= 4'd0;
                        out_result <= fpu_o;
                        out_flags  <= flags_nxt;
                        out_tag    <= tag_q;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Handshake outputs come straight from state; in_ready is also blocked during reset.
    always_comb begin
        in_ready  = (state == IDLE) && !rst;
        out_valid = (state == DONE);
        busy      = (state != IDLE);
    end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
module tb_fpu_issue_ctrl;

    localparam int LAT_ADD  = 4;
    localparam int LAT_SQRT = 8;
    localparam int LAT_MUL  = 4;
    localparam int LAT_DIV  = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a, in_b;
    logic [1:0]  in_op;
    logic [3:0]  in_tag;
    logic [31:0] fpu_a, fpu_b;
    logic [1:0]  fpu_s;
    logic [31:0] fpu_o;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [3:0]  out_tag;
    logic [2:0]  out_flags;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fpu_issue_ctrl #(
        .LAT_ADD (LAT_ADD),
        .LAT_SQRT(LAT_SQRT),
        .LAT_MUL (LAT_MUL),
        .LAT_DIV (LAT_DIV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .in_tag    (in_tag),
        .fpu_a     (fpu_a),
        .fpu_b     (fpu_b),
        .fpu_s     (fpu_s),
        .fpu_o     (fpu_o),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_result(out_result),
        .out_tag   (out_tag),
        .out_flags (out_flags),
        .busy      (busy)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        logic [3:0]  tag;
        logic [31:0] res;
        int          hold;
        logic [2:0]  flags;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic int lat_of(input logic [1:0] op);
        case (op)
            2'b00:   return LAT_ADD;
            2'b01:   return LAT_SQRT;
            2'b10:   return LAT_MUL;
            default: return LAT_DIV;
        endcase
    endfunction

    function automatic logic [2:0] classify(input logic [31:0] v);
        logic [7:0]  e;
        logic [22:0] m;
        e = v[30:23];
        m = v[22:0];
        return {(e == 8'hFF) && (m != 0), (e == 8'hFF) && (m == 0), e == 8'h00};
    endfunction

    task automatic chk_reset_vals(input string nm);
        chk({nm, ":fpu_a"},      fpu_a, 32'd0);
        chk({nm, ":fpu_b"},      fpu_b, 32'd0);
        chk({nm, ":fpu_s"},      32'(fpu_s), 32'd0);
        chk({nm, ":out_result"}, out_result, 32'd0);
        chk({nm, ":out_tag"},    32'(out_tag), 32'd0);
        chk({nm, ":out_flags"},  32'(out_flags), 32'd0);
        chk({nm, ":out_valid"},  32'(out_valid), 32'd0);
        chk({nm, ":busy"},       32'(busy), 32'd0);
        chk({nm, ":in_ready"},   32'(in_ready), 32'd0);
    endtask

    // Model FPU: fpu_o holds a value different from the result except during the one
    // cycle before edge E0+LAT, so any capture at the wrong edge picks up junk.
    task automatic run_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] op, input logic [3:0] tag, input logic [31:0] res,
                          input int hold, input logic [2:0] eflags);
        int lat;
        logic [31:0] junk;
        lat  = lat_of(op);
        junk = res ^ 32'hA5A5_5A5A;
        @(negedge clk);
        chk({nm, ":idle_in_ready"}, 32'(in_ready), 32'd1);
        chk({nm, ":idle_busy"},     32'(busy), 32'd0);
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_op     = op;
        in_tag    = tag;
        out_ready = (hold == 0);
        fpu_o     = junk;
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            if (k == 1) in_valid = 1'b0;
            in_a   = $urandom;
            in_b   = $urandom;
            in_op  = 2'($urandom_range(0, 3));
            in_tag = 4'($urandom_range(0, 15));
            chk({nm, ":wait_fpu_a"},     fpu_a, a);
            chk({nm, ":wait_fpu_b"},     fpu_b, b);
            chk({nm, ":wait_fpu_s"},     32'(fpu_s), 32'(op));
            chk({nm, ":wait_out_valid"}, 32'(out_valid), 32'd0);
            chk({nm, ":wait_in_ready"},  32'(in_ready), 32'd0);
            chk({nm, ":wait_busy"},      32'(busy), 32'd1);
            fpu_o = (k == lat) ? res : junk;
        end
        @(negedge clk);
        fpu_o = junk;
        chk({nm, ":done_valid"},    32'(out_valid), 32'd1);
        chk({nm, ":done_result"},   out_result, res);
        chk({nm, ":done_tag"},      32'(out_tag), 32'(tag));
        chk({nm, ":done_flags"},    32'(out_flags), 32'(eflags));
        chk({nm, ":done_in_ready"}, 32'(in_ready), 32'd0);
        for (int h = 0; h < hold; h++) begin
            // A competing request during backpressure must be ignored.
            in_valid = 1'b1;
            in_a     = ~a;
            in_b     = ~b;
            in_op    = ~op;
            in_tag   = ~tag;
            @(negedge clk);
            chk({nm, ":bp_valid"},    32'(out_valid), 32'd1);
            chk({nm, ":bp_result"},   out_result, res);
            chk({nm, ":bp_tag"},      32'(out_tag), 32'(tag));
            chk({nm, ":bp_in_ready"}, 32'(in_ready), 32'd0);
            chk({nm, ":bp_fpu_a"},    fpu_a, a);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk({nm, ":post_valid"},    32'(out_valid), 32'd0);
        chk({nm, ":post_in_ready"}, 32'(in_ready), 32'd1);
        chk({nm, ":post_fpu_a"},    fpu_a, a);
        chk({nm, ":post_fpu_s"},    32'(fpu_s), 32'(op));
    endtask

    initial begin
        logic [31:0] ra, rb, rres;
        logic [1:0]  rop;
        logic [3:0]  rtag;
        int          sel;
        bit          seen_valid;

        vecs[0] = '{32'h3F800000, 32'h40000000, 2'b00, 4'd5, 32'h40400000, 0, 3'b000};
        vecs[1] = '{32'h40800000, 32'h00000000, 2'b01, 4'd1, 32'h40000000, 0, 3'b000};
        vecs[2] = '{32'h40000000, 32'h40400000, 2'b10, 4'd2, 32'h40C00000, 0, 3'b000};
        vecs[3] = '{32'h40C00000, 32'h40000000, 2'b11, 4'd3, 32'h40400000, 0, 3'b000};
        vecs[4] = '{32'h3F800000, 32'h40400000, 2'b11, 4'd4, 32'h3EAAAAAB, 6, 3'b000};
        vecs[5] = '{32'h7F800000, 32'hFF800000, 2'b00, 4'd6, 32'h7FC00000, 0, 3'b100};
        vecs[6] = '{32'h7F000000, 32'h40000000, 2'b10, 4'd7, 32'h7F800000, 0, 3'b010};
        vecs[7] = '{32'h80000000, 32'h00000000, 2'b01, 4'd8, 32'h80000000, 0, 3'b001};
        vecs[8] = '{32'h00800000, 32'h4B000000, 2'b11, 4'd9, 32'h00000001, 2, 3'b001};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = 32'd0;
        in_b      = 32'd0;
        in_op     = 2'b00;
        in_tag    = 4'd0;
        fpu_o     = 32'd0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b0;

        for (int i = 0; i < 9; i++)
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].tag,
                   vecs[i].res, vecs[i].hold, vecs[i].flags);

        // Reset two cycles into a divide: request must vanish entirely.
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = 32'h41200000;
        in_b     = 32'h40000000;
        in_op    = 2'b11;
        in_tag   = 4'd12;
        fpu_o    = 32'h40A00000;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_reset_vals("midwait_rst");
        @(negedge clk);
        rst = 1'b0;
        seen_valid = 1'b0;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (out_valid) seen_valid = 1'b1;
        end
        chk("midwait_no_valid", 32'(seen_valid), 32'd0);
        run_op("after_rst_add", 32'h3F800000, 32'h3F800000, 2'b00, 4'd10, 32'h40000000, 0, 3'b000);

        // Randomized traffic against the latency table and flag rules.
        for (int n = 0; n < 40; n++) begin
            ra   = $urandom;
            rb   = $urandom;
            rop  = 2'($urandom_range(0, 3));
            rtag = 4'($urandom_range(0, 15));
            rres = $urandom;
            sel  = $urandom_range(0, 5);
            case (sel)
                0: rres[30:23] = 8'hFF;
                1: begin rres[30:23] = 8'hFF; rres[22:0] = 23'd0; end
                2: rres[30:23] = 8'h00;
                default: ;
            endcase
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_op($sformatf("rand%0d", n), ra, rb, rop, rtag, rres,
                   $urandom_range(0, 3), classify(rres));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
